mdbrot_fixed_renderer: RTL
==========================

# mdbrot_fixed_renderer

Parametrised escape-time Mandelbrot renderer. It walks an H_RES×V_RES raster in row-major order and maps each pixel to a point c in the complex plane using a signed fixed-point origin and step. It iterates z←z²+c at one iteration per clock and emits one coloured pixel per point over a valid/ready handshake. It sits between the frame-start control and the VGA pixel writer, and is the successor to the fixed 160×120 integer renderer.

## Interface
- H_RES, 160, pixels per row (≥1)
- V_RES, 120, rows per frame (≥1)
- X_W, 8, width of vga_x (2^X_W ≥ H_RES)
- Y_W, 7, width of vga_y (2^Y_W ≥ V_RES)
- FRAC, 12, fractional bits; fixed-point format is signed Q4.FRAC, DW = 4+FRAC
- ITER_W, 13, iteration counter width
- COL_W, 3, colour width
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  frame request, sampled only in IDLE
- max_iter  in  ITER_W  iteration limit, latched on start
- cx0, cy0  in  DW  signed real/imag of pixel (0,0), latched on start
- step  in  DW  unsigned per-pixel increment (x→+real, y→+imag), latched on start
- vga_ready  in  1  sink accepts pixel
- vga_x  out  X_W  pixel column
- vga_y  out  Y_W  pixel row
- vga_colour  out  COL_W  pixel colour
- vga_plot  out  1  pixel valid
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse after the last pixel handshake

## Operation
- States: IDLE, INIT, ITER, EMIT, DONE.
- IDLE: when start=1, latch max_iter/cx0/cy0/step, set x=y=0, cr=cx0, ci=cy0, go to INIT.
- INIT: zr=zi=0, iter=0, then go to ITER.
- ITER, evaluated in priority order:
  - If iter==max_iter, go to EMIT.
  - Else if zr²+zi² > 4.0, go to EMIT.
  - Else apply zr'=zr²−zi²+cr, zi'=2·zr·zi+ci, iter+1.
- EMIT: vga_plot=1 with x, y and colour. On vga_ready:
  - If x<H_RES−1: x+1, cr+=step, go to INIT.
  - Else if y<V_RES−1: x=0, y+1, cr=cx0, ci+=step, go to INIT.
  - Else go to DONE.
- DONE: done=1 for one cycle, then IDLE.
- Colour:
  - iter==max_iter gives 0.
  - Otherwise colour is iter[COL_W−1:0].
- Arithmetic:
  - Products are full 2·DW signed.
  - Squares and zr·zi are arithmetic-shifted right by FRAC, then truncated to DW for the update.
  - The escape comparison uses the un-truncated sum in 2·DW+1 bits against 4<<FRAC.
  - The operating range is |c| ≤ 4; outside that range overflow wraps and is not flagged.
  - cr/ci accumulate in DW bits with wrap.

## Timing
- Reset values: state IDLE; vga_x=0, vga_y=0, vga_colour=0, vga_plot=0, busy=0, done=0; all internal registers 0.
- Reset mid-frame aborts immediately. No partial done is produced.
- Outputs are registered or decoded from registered state only. vga_x/vga_y/vga_colour are 0 whenever vga_plot=0.
- Per-pixel latency with vga_ready held high is k+3 cycles, where k = iterations performed: INIT 1, ITER k+1, EMIT 1.
- Handshake:
  - A transfer occurs on a cycle with vga_plot & vga_ready.
  - vga_plot stays high and x/y/colour stay stable until the transfer.
  - vga_ready is ignored outside EMIT.
- start is ignored while busy. start is level-sampled, so start held high through DONE→IDLE begins a new frame one cycle after IDLE.
- max_iter=0: every pixel emits colour 0 after 3 cycles.
- Last-pixel transfer at cycle t gives done=1 at t+1, and busy=0 from t+2.

## Structure
- Package mdbrot_pkg holds:
  - The state enum.
  - The fixed-point helper constant FOUR_FX(FRAC).
  - The colour function.
- Sub-module mdbrot_iter_core is the combinational single-step datapath. It takes zr, zi, cr, ci and produces zr', zi' and escape. It is parametrised by FRAC.
- The top level holds the FSM, raster counters, coordinate accumulators and the output register.

## Test plan
- H_RES=V_RES=1, FRAC=12, cx0=cy0=0, max_iter=20 → one pixel (0,0), colour 0, vga_plot 23 cycles after start, then done pulse.
- cx0=2.0 (0x2000), cy0=0, max_iter=20 → escapes after 2 iterations, colour 2, plot at cycle 5.
- cx0=−2.0, cy0=0, max_iter=100 → never escapes, colour 0. This exercises the equality boundary |z|²=4.
- H_RES=4, V_RES=2, max_iter=0, step=0x0100 → 8 transfers in order (0,0),(1,0),(2,0),(3,0),(0,1)…(3,1), all colour 0, then a single done.
- During EMIT hold vga_ready low for 5 cycles → vga_plot and x/y/colour held constant, with exactly one transfer when vga_ready rises.
- Assert rst while in ITER mid-frame → all outputs 0 in the same cycle, busy low. A new start then begins at pixel (0,0) with freshly latched cx0.

Source files
------------

// File: rtl/mdbrot_pkg.sv
// Shared types and fixed-point helpers for the escape-time Mandelbrot renderer.
package mdbrot_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_ITER,
    S_EMIT,
    S_DONE
  } state_t;

  // 4.0 expressed with 'frac' fractional bits.
  function automatic longint FOUR_FX(input int frac);
    return longint'(4) << frac;
  endfunction

  // Points that hit the iteration limit are painted 0; escapees use the iteration count.
  function automatic logic [31:0] colour_of(input logic [31:0] iter, input logic [31:0] max_iter);
    return (iter == max_iter) ? 32'd0 : iter;
  endfunction

endpackage

// File: rtl/mdbrot_iter_core.sv
// One z <- z^2 + c step in signed Q4.FRAC, plus the |z|^2 > 4 escape test on the current z.
module mdbrot_iter_core
  import mdbrot_pkg::*;
#(
  parameter int FRAC = 12
) (
  input  logic [FRAC+3:0] zr,
  input  logic [FRAC+3:0] zi,
  input  logic [FRAC+3:0] cr,
  input  logic [FRAC+3:0] ci,
  output logic [FRAC+3:0] zr_next,
  output logic [FRAC+3:0] zi_next,
  output logic            escape
);

  localparam int DW = FRAC + 4;
  localparam int PW = 2 * DW;
  localparam int SW = PW + 1;
  localparam logic signed [SW-1:0] FOUR = SW'(FOUR_FX(FRAC));

  logic signed [PW-1:0] zr_w, zi_w;
  logic signed [PW-1:0] zr2, zi2, zrzi;
  logic signed [SW-1:0] mag;

  assign zr_w = PW'($signed(zr));
  assign zi_w = PW'($signed(zi));

  assign zr2  = (zr_w * zr_w) >>> FRAC;
  assign zi2  = (zi_w * zi_w) >>> FRAC;
  assign zrzi = (zr_w * zi_w) >>> FRAC;

  // Escape uses the full-width sum so large |z| cannot wrap below the threshold.
  assign mag    = SW'(zr2) + SW'(zi2);
  assign escape = (mag > FOUR);

  assign zr_next = DW'(zr2 - zi2) + cr;
  assign zi_next = DW'(zrzi <<< 1) + ci;

endmodule

// File: rtl/mdbrot_fixed_renderer.sv
// Raster-walking Mandelbrot renderer: one iteration per clock, one pixel per valid/ready transfer.
module mdbrot_fixed_renderer
  import mdbrot_pkg::*;
#(
  parameter int H_RES  = 160,
  parameter int V_RES  = 120,
  parameter int X_W    = 8,
  parameter int Y_W    = 7,
  parameter int FRAC   = 12,
  parameter int ITER_W = 13,
  parameter int COL_W  = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [ITER_W-1:0]       max_iter,
  input  logic signed [FRAC+3:0]  cx0,
  input  logic signed [FRAC+3:0]  cy0,
  input  logic [FRAC+3:0]         step,
  input  logic                    vga_ready,
  output logic [X_W-1:0]          vga_x,
  output logic [Y_W-1:0]          vga_y,
  output logic [COL_W-1:0]        vga_colour,
  output logic                    vga_plot,
  output logic                    busy,
  output logic                    done
);

  localparam int DW = FRAC + 4;
  localparam logic [X_W-1:0] X_LAST = X_W'(H_RES - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(V_RES - 1);

  // Handshake: a pixel transfers on any cycle with vga_plot & vga_ready; vga_plot and
  // x/y/colour hold steady until then, and vga_ready is ignored outside EMIT.
  state_t state, state_next;

  logic [X_W-1:0]    x;
  logic [Y_W-1:0]    y;
  logic [DW-1:0]     cr, ci, cx0_q, step_q;
  logic [DW-1:0]     zr, zi, zr_next, zi_next;
  logic [ITER_W-1:0] iter, max_q;
  logic [COL_W-1:0]  colour_q, colour_now;
  logic              escape, at_max, xfer;

  assign at_max     = (iter == max_q);
  assign colour_now = COL_W'(colour_of(32'(iter), 32'(max_q)));
  assign xfer       = (state == S_EMIT) && vga_ready;

  mdbrot_iter_core #(.FRAC(FRAC)) u_core (
    .zr      (zr),
    .zi      (zi),
    .cr      (cr),
    .ci      (ci),
    .zr_next (zr_next),
    .zi_next (zi_next),
    .escape  (escape)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (start) state_next = S_INIT;
      S_INIT: state_next = S_ITER;
      S_ITER: if (at_max || escape) state_next = S_EMIT;
      S_EMIT: begin
        if (vga_ready) begin
          if (x < X_LAST || y < Y_LAST) state_next = S_INIT;
          else                          state_next = S_DONE;
        end
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x        <= '0;
      y        <= '0;
      cr       <= '0;
      ci       <= '0;
      cx0_q    <= '0;
      step_q   <= '0;
      zr       <= '0;
      zi       <= '0;
      iter     <= '0;
      max_q    <= '0;
      colour_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            max_q  <= max_iter;
            cx0_q  <= cx0;
            step_q <= step;
            x      <= '0;
            y      <= '0;
            cr     <= cx0;
            ci     <= cy0;
          end
        end
        S_INIT: begin
          zr   <= '0;
          zi   <= '0;
          iter <= '0;
        end
        S_ITER: begin
          // The limit check wins over escape, so a limit hit always paints 0.
          if (at_max || escape) begin
            colour_q <= colour_now;
          end else begin
            zr   <= zr_next;
            zi   <= zi_next;
            iter <= iter + 1'b1;
          end
        end
        S_EMIT: begin
          if (xfer) begin
            if (x < X_LAST) begin
              x  <= x + 1'b1;
              cr <= cr + step_q;
            end else if (y < Y_LAST) begin
              x  <= '0;
              y  <= y + 1'b1;
              cr <= cx0_q;
              ci <= ci + step_q;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign vga_plot   = (state == S_EMIT);
  assign vga_x      = vga_plot ? x : '0;
  assign vga_y      = vga_plot ? y : '0;
  assign vga_colour = vga_plot ? colour_q : '0;
  assign busy       = (state != S_IDLE);
  assign done       = (state == S_DONE);

endmodule
